// File: rtl/lcd_host.sv
// LCD host: walks a command ROM, issues each code to the display controller
// with busy/done handshaking, and captures the bytes the controller writes back.
module lcd_host (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        CMD_rd,
  output logic [5:0]  CMD_A,
  input  logic [3:0]  CMD_Q,
  output logic [3:0]  cmd,
  output logic        cmd_valid,
  input  logic        busy,
  input  logic        done,
  input  logic        IRAM_valid,
  input  logic [7:0]  IRAM_D,
  input  logic [5:0]  IRAM_A,
  input  logic [5:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [13:0] checksum,
  output logic [6:0]  wr_count,
  output logic        finished,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_FIN
  } state_t;

  state_t      r_state;
  logic [5:0]  r_pc;
  logic [3:0]  r_cmdReg;
  logic [1:0]  r_timer;
  logic        r_doneSeen;
  logic        r_cmdRd;
  logic [5:0]  r_cmdA;
  logic [3:0]  r_cmd;
  logic        r_cmdValid;
  logic        r_finished;
  logic        r_err;
  logic [13:0] r_checksum;
  logic [6:0]  r_wrCount;
  logic [7:0]  r_mem [0:63];

  logic        w_clear;
  logic        w_doneAny;
  logic [5:0]  w_nextPc;

  assign w_clear   = (r_state == S_IDLE) && start;
  assign w_doneAny = done || r_doneSeen;
  assign w_nextPc  = r_pc + 6'd1;

  // Sequencer; codes above 11 are flagged and skipped, code 0 (image write) ends the run once done is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_cmdReg   <= '0;
      r_timer    <= '0;
      r_doneSeen <= 1'b0;
      r_cmdRd    <= 1'b0;
      r_cmdA     <= '0;
      r_cmd      <= '0;
      r_cmdValid <= 1'b0;
      r_finished <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cmdRd    <= 1'b0;
      r_cmdValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc       <= '0;
            r_cmdA     <= '0;
            r_cmdRd    <= 1'b1;
            r_finished <= 1'b0;
            r_err      <= 1'b0;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_cmdReg <= CMD_Q;
          if (CMD_Q > 4'd11) begin
            r_err <= 1'b1;
            if (r_pc == 6'd63) begin
              r_finished <= 1'b1;
              r_state    <= S_FIN;
            end else begin
              r_pc    <= w_nextPc;
              r_cmdA  <= w_nextPc;
              r_cmdRd <= 1'b1;
              r_state <= S_FETCH;
            end
          end else begin
            r_cmd   <= CMD_Q;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!busy) begin
            r_cmdValid <= 1'b1;
            r_timer    <= '0;
            r_doneSeen <= 1'b0;
            r_state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (done) r_doneSeen <= 1'b1;
          if (busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_timer == 2'd3) begin
            r_err   <= 1'b1;
            r_state <= S_WAIT_LO;
          end else begin
            r_timer <= r_timer + 2'd1;
          end
        end
        S_WAIT_LO: begin
          if (done) r_doneSeen <= 1'b1;
          if (!busy) begin
            if (r_cmdReg == 4'd0) begin
              if (w_doneAny) begin
                r_cmd      <= '0;
                r_finished <= 1'b1;
                r_state    <= S_FIN;
              end
            end else if (r_pc == 6'd63) begin
              r_err      <= 1'b1;
              r_cmd      <= '0;
              r_finished <= 1'b1;
              r_state    <= S_FIN;
            end else begin
              r_cmd   <= '0;
              r_pc    <= w_nextPc;
              r_cmdA  <= w_nextPc;
              r_cmdRd <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_FIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture statistics; a start accepted in IDLE wins over a same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
      r_wrCount  <= '0;
    end else if (w_clear) begin
      r_checksum <= '0;
      r_wrCount  <= '0;
    end else if (IRAM_valid) begin
      r_checksum <= r_checksum + {6'd0, IRAM_D};
      if (r_wrCount != 7'd127) r_wrCount <= r_wrCount + 7'd1;
    end
  end

  // Capture memory is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (IRAM_valid) r_mem[IRAM_A] <= IRAM_D;
  end

  assign rd_data   = r_mem[rd_addr];
  assign CMD_rd    = r_cmdRd;
  assign CMD_A     = r_cmdA;
  assign cmd       = r_cmd;
  assign cmd_valid = r_cmdValid;
  assign checksum  = r_checksum;
  assign wr_count  = r_wrCount;
  assign finished  = r_finished;
  assign err       = r_err;

endmodule

// File: tb/tb_lcd_host.sv
// Bench for lcd_host: ROM and controller models drive the host, a spec-level
// model predicts the command stream and capture statistics.
module tb_lcd_host;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        CMD_rd;
  logic [5:0]  CMD_A;
  logic [3:0]  CMD_Q = '0;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        busy;
  logic        done;
  logic        IRAM_valid;
  logic [7:0]  IRAM_D;
  logic [5:0]  IRAM_A;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [13:0] checksum;
  logic [6:0]  wr_count;
  logic        finished;
  logic        err;

  logic        ctlBusy, ctlDone, ctlValid;
  logic [5:0]  ctlA;
  logic [7:0]  ctlD;
  logic        stimValid;
  logic [5:0]  stimA;
  logic [7:0]  stimD;
  int          ctlMode = 0;
  bit          ctlRelease = 1'b0;

  logic [3:0]  rom [0:63];
  logic [3:0]  expQ [$];
  bit          expErr;

  int          mCsum;
  int          mCount;
  logic [7:0]  mMem [0:63];
  bit          mWritten [0:63];

  int          vectors = 0;
  int          miscompares = 0;

  assign busy       = ctlBusy;
  assign done       = ctlDone;
  assign IRAM_valid = ctlValid | stimValid;
  assign IRAM_A     = stimValid ? stimA : ctlA;
  assign IRAM_D     = stimValid ? stimD : ctlD;

  lcd_host dut (
    .clk(clk), .reset(reset), .start(start),
    .CMD_rd(CMD_rd), .CMD_A(CMD_A), .CMD_Q(CMD_Q),
    .cmd(cmd), .cmd_valid(cmd_valid),
    .busy(busy), .done(done),
    .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .checksum(checksum), .wr_count(wr_count),
    .finished(finished), .err(err)
  );

  always #5 clk = ~clk;

  // Command ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (CMD_rd) CMD_Q <= rom[CMD_A];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Expected command stream: walk the ROM, skip bad codes, stop after an image write or address 63.
  function automatic void buildExpectation(input bit ignoreCmd2);
    bit found = 1'b0;
    expQ.delete();
    expErr = 1'b0;
    for (int p = 0; p < 64; p++) begin
      if (!found) begin
        if (rom[p] > 4'd11) expErr = 1'b1;
        else begin
          if (ignoreCmd2 && rom[p] == 4'd2) expErr = 1'b1;
          expQ.push_back(rom[p]);
          if (rom[p] == 4'd0) found = 1'b1;
        end
      end
    end
    if (!found) expErr = 1'b1;
  endfunction

  // Capture model: running sum mod 2^14, saturating count, last-write memory.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mCsum  = 0;
      mCount = 0;
    end else begin
      if (IRAM_valid) begin
        mMem[IRAM_A]     = IRAM_D;
        mWritten[IRAM_A] = 1'b1;
      end
      if (start) begin
        mCsum  = 0;
        mCount = 0;
      end else if (IRAM_valid) begin
        mCsum  = (mCsum + int'(IRAM_D)) % 16384;
        mCount = (mCount < 127) ? mCount + 1 : 127;
      end
    end
  end

  // Per-cycle compare against the model and the expected command queue.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checkOutput("checksum", 32'(checksum), 32'(mCsum));
      checkOutput("wr_count", 32'(wr_count), 32'(mCount));
      if (mWritten[rd_addr]) checkOutput("rd_data", 32'(rd_data), 32'(mMem[rd_addr]));
      if (cmd_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpectedCmd: got cmd_valid with cmd %0d, expected none", cmd);
        end else begin
          checkOutput("cmd", 32'(cmd), 32'(expQ.pop_front()));
        end
      end
    end
  end

  task automatic runController(input logic [3:0] c);
    if (ctlMode == 2) begin
      @(posedge clk); #1;
      ctlBusy = 1'b1;
      for (int i = 0; i < 3; i++) begin
        ctlValid = 1'b1; ctlA = 6'(40 + i); ctlD = 8'h11;
        @(posedge clk); #1;
      end
      ctlValid = 1'b0;
      while (!ctlRelease) @(posedge clk);
      #1 ctlBusy = 1'b0;
    end else if (ctlMode == 1 && c == 4'd2) begin
      ctlBusy = 1'b0;
    end else if (c == 4'd0) begin
      @(posedge clk); #1;
      ctlBusy = 1'b1;
      for (int a = 0; a < 64; a++) begin
        ctlValid = 1'b1; ctlA = 6'(a); ctlD = 8'(a);
        @(posedge clk); #1;
      end
      ctlValid = 1'b0; ctlBusy = 1'b0; ctlDone = 1'b1;
      @(posedge clk); #1;
      ctlDone = 1'b0;
    end else begin
      @(posedge clk); #1 ctlBusy = 1'b1;
      @(posedge clk); #1 ctlBusy = 1'b0;
    end
  endtask

  initial begin
    ctlBusy = 1'b0; ctlDone = 1'b0; ctlValid = 1'b0; ctlA = '0; ctlD = '0;
    forever begin
      @(negedge clk);
      if (cmd_valid === 1'b1) runController(cmd);
    end
  end

  task automatic applyStimulus(input bit withWrite, input logic [5:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    start = 1'b1;
    if (withWrite) begin
      stimValid = 1'b1; stimA = a; stimD = d;
    end
    @(posedge clk); #1;
    start = 1'b0;
    stimValid = 1'b0;
  endtask

  task automatic endTest(input string name, input int budget);
    int n = 0;
    while (finished !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_finished"}, 32'(finished), 32'd1);
    checkOutput({name, "_err"}, 32'(err), 32'(expErr));
    checkOutput({name, "_pending"}, 32'(expQ.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic waitCmd(input logic [3:0] c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cmd_valid === 1'b1 && cmd == c) && n < 30);
    checkOutput("cmdSeen", 32'(cmd_valid), 32'd1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b0; rd_addr = '0;
    stimValid = 1'b0; stimA = '0; stimD = '0;
    for (int i = 0; i < 64; i++) rom[i] = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_CMD_rd", 32'(CMD_rd), 0);
    checkOutput("rst_CMD_A", 32'(CMD_A), 0);
    checkOutput("rst_cmd", 32'(cmd), 0);
    checkOutput("rst_cmd_valid", 32'(cmd_valid), 0);
    checkOutput("rst_checksum", 32'(checksum), 0);
    checkOutput("rst_wr_count", 32'(wr_count), 0);
    checkOutput("rst_finished", 32'(finished), 0);
    checkOutput("rst_err", 32'(err), 0);
    @(posedge clk); #1 reset = 1'b0;

    $display("[TB] capture path: wrap, saturation, repeated address");
    rd_addr = 6'd10;
    @(posedge clk); #1;
    stimValid = 1'b1; stimA = 6'd10; stimD = 8'hFF;
    repeat (130) @(posedge clk);
    #1 stimD = 8'h5A;
    @(posedge clk); #1 stimValid = 1'b0;
    @(negedge clk);
    checkOutput("cap_checksum", 32'(checksum), 32'd472);
    checkOutput("cap_wr_count", 32'(wr_count), 32'd127);
    checkOutput("cap_rd_data", 32'(rd_data), 32'h5A);

    $display("[TB] ROM {4,1,0} with start-coincident write");
    rom[0] = 4'd4; rom[1] = 4'd1; rom[2] = 4'd0;
    buildExpectation(1'b0);
    checkOutput("model_len_410", 32'(expQ.size()), 32'd3);
    rd_addr = 6'd20;
    applyStimulus(1'b1, 6'd20, 8'h77);
    @(negedge clk);
    checkOutput("clr_checksum", 32'(checksum), 0);
    checkOutput("clr_wr_count", 32'(wr_count), 0);
    checkOutput("clr_rd_data", 32'(rd_data), 32'h77);
    checkOutput("lat_valid0", 32'(cmd_valid), 0);
    @(negedge clk); checkOutput("lat_valid1", 32'(cmd_valid), 0);
    @(negedge clk); checkOutput("lat_valid2", 32'(cmd_valid), 0);
    @(negedge clk);
    checkOutput("lat_valid3", 32'(cmd_valid), 1);
    checkOutput("lat_cmd3", 32'(cmd), 4);
    endTest("seq410", 400);
    checkOutput("seq410_checksum", 32'(checksum), 32'd2016);
    checkOutput("seq410_wr_count", 32'(wr_count), 32'd64);
    @(posedge clk); #1 rd_addr = 6'd37;
    @(negedge clk);
    checkOutput("seq410_rd37", 32'(rd_data), 32'd37);

    $display("[TB] ROM {13,4,0}: invalid code skipped");
    rom[0] = 4'd13; rom[1] = 4'd4; rom[2] = 4'd0;
    buildExpectation(1'b0);
    checkOutput("model_err_13", 32'(expErr), 1);
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);
    checkOutput("bad_fetch_rd", 32'(CMD_rd), 1);
    checkOutput("bad_fetch_a", 32'(CMD_A), 0);
    @(negedge clk);
    checkOutput("bad_latch_rd", 32'(CMD_rd), 0);
    checkOutput("bad_latch_err", 32'(err), 0);
    @(negedge clk);
    checkOutput("bad_err", 32'(err), 1);
    checkOutput("bad_next_rd", 32'(CMD_rd), 1);
    checkOutput("bad_next_a", 32'(CMD_A), 1);
    endTest("seqBad", 400);

    $display("[TB] ROM {2,0}: controller ignores cmd 2");
    rom[0] = 4'd2; rom[1] = 4'd0; rom[2] = 4'd0;
    ctlMode = 1;
    buildExpectation(1'b1);
    applyStimulus(1'b0, '0, '0);
    waitCmd(4'd2);
    repeat (3) @(negedge clk);
    checkOutput("to_err_c3", 32'(err), 0);
    @(negedge clk);
    checkOutput("to_err_c4", 32'(err), 1);
    endTest("seqTimeout", 400);
    ctlMode = 0;

    $display("[TB] 64 non-write commands");
    for (int i = 0; i < 64; i++) rom[i] = 4'd5;
    buildExpectation(1'b0);
    checkOutput("model_len_64", 32'(expQ.size()), 32'd64);
    applyStimulus(1'b0, '0, '0);
    endTest("seqRun64", 3000);

    $display("[TB] reset during WAIT_LO");
    rom[0] = 4'd3; rom[1] = 4'd0;
    ctlMode = 2; ctlRelease = 1'b0;
    buildExpectation(1'b0);
    applyStimulus(1'b0, '0, '0);
    waitCmd(4'd3);
    repeat (8) @(negedge clk);
    checkOutput("hang_cmd", 32'(cmd), 3);
    checkOutput("hang_checksum", 32'(checksum), 32'd51);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    checkOutput("mid_CMD_rd", 32'(CMD_rd), 0);
    checkOutput("mid_CMD_A", 32'(CMD_A), 0);
    checkOutput("mid_cmd", 32'(cmd), 0);
    checkOutput("mid_cmd_valid", 32'(cmd_valid), 0);
    checkOutput("mid_checksum", 32'(checksum), 0);
    checkOutput("mid_wr_count", 32'(wr_count), 0);
    checkOutput("mid_finished", 32'(finished), 0);
    checkOutput("mid_err", 32'(err), 0);
    expQ.delete();
    ctlRelease = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) cnt++;
    end
    checkOutput("noCmdAfterReset", 32'(cnt), 0);
    ctlMode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_host.md
LCD_HOST -- requirements
Module: lcd_host

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle pulse; begins command sequence from command address 0; ignored unless in IDLE.
REQ-004 CMD_rd  output  1  command ROM read strobe.
REQ-005 CMD_A  output  6  command ROM address.
REQ-006 CMD_Q  input  4  command code; valid the cycle after CMD_rd=1 with CMD_A.
REQ-007 cmd  output  4  command to controller.
REQ-008 cmd_valid  output  1  one-cycle command-issue strobe.
REQ-009 busy  input  1  controller busy.
REQ-010 done  input  1  controller image-write complete.
REQ-011 IRAM_valid  input  1  controller write strobe.
REQ-012 IRAM_D  input  8  write data.
REQ-013 IRAM_A  input  6  write address.
REQ-014 rd_addr  input  6  readback address.
REQ-015 rd_data  output  8  captured byte at rd_addr, combinational.
REQ-016 checksum  output  14  sum of accepted write data, mod 2^14.
REQ-017 wr_count  output  7  accepted writes, saturating at 127.
REQ-018 finished  output  1  sequence complete, sticky until next start.
REQ-019 err  output  1  sticky error flag, cleared by start or reset.

Function
REQ-020 FSM states: IDLE, FETCH, LATCH, ISSUE, WAIT_HI, WAIT_LO, FIN.
REQ-021 IDLE: start=1 -> pc=0, finished=0, err=0, checksum=0, wr_count=0; go FETCH.
REQ-022 FETCH: CMD_rd=1, CMD_A=pc for exactly one cycle; go LATCH.
REQ-023 LATCH: register CMD_Q into cmd_reg; CMD_rd=0; if CMD_Q>11, set err, skip to next pc (REQ-027); else go ISSUE.
REQ-024 ISSUE: wait while busy=1; on first cycle with busy=0, drive cmd=cmd_reg, cmd_valid=1 for one cycle; go WAIT_HI.
REQ-025 cmd holds cmd_reg from ISSUE until the state after WAIT_LO; cmd_valid is never high in any other state.
REQ-026 WAIT_HI: go WAIT_LO when busy=1; if busy not seen within 4 cycles after cmd_valid, set err and go WAIT_LO.
REQ-027 WAIT_LO: on busy=0 -> if cmd_reg=0 and done=1 (seen in this or any earlier cycle since issue), go FIN; else if pc=63, set err and go FIN; else pc<=pc+1, go FETCH.
REQ-028 cmd_reg=0 completes only with done; busy=0 without done for write keeps state WAIT_LO.
REQ-029 FIN: finished=1; go IDLE next cycle; finished remains 1 in IDLE until start.
REQ-030 Capture path independent of FSM: each cycle IRAM_valid=1 -> mem[IRAM_A]<=IRAM_D, checksum<=checksum+IRAM_D (mod 2^14), wr_count<=min(wr_count+1,127).
REQ-031 Repeated writes to one address: mem keeps last value; checksum and wr_count count every write.
REQ-032 start concurrent with IRAM_valid in IDLE: clear takes precedence; that write updates mem only.
REQ-033 Command latency: cmd_valid no earlier than 3 cycles after start (FETCH, LATCH, ISSUE).

Reset
REQ-034 reset=1 asynchronously forces IDLE; CMD_rd=0, CMD_A=0, cmd=0, cmd_valid=0, checksum=0, wr_count=0, finished=0, err=0, pc=0.
REQ-035 Reset mid-sequence aborts immediately; no further cmd_valid until a new start after reset release.
REQ-036 Capture memory contents are not reset; readback defined only for written addresses.

Verification
REQ-037 ROM {4,1,0}, controller model busy 1 cycle per move, 64 writes at done -> cmd_valid carrying 4,1,0 in order, finished=1, err=0.
REQ-038 ROM {13,...} -> err=1 after LATCH, no cmd_valid for 13, next address fetched.
REQ-039 Writes IRAM_D=addr for addr 0..63 -> checksum=2016, wr_count=64, rd_data(37)=37.
REQ-040 Controller never raises busy after cmd 2 -> err=1 four cycles after cmd_valid, sequence continues.
REQ-041 64 non-write commands -> finished=1, err=1 after address 63.
REQ-042 Reset during WAIT_LO -> all outputs zero same cycle, no cmd_valid until next start.
